pill_feeder: RTL and testbench

PILL_FEEDER -- requirements
Module: pill_feeder

---
 rtl/pill_feeder.sv | 201 ++++++++++++++++++++
 tb/tb_pill_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pill_feeder.sv
// -----------------------------------------------------------------------------
// pill_feeder
//   Drives a pill dispenser and bottle conveyor. A FEED state emits one pill
//   pulse every max(period,1) cycles and keeps a BCD count of pills in the
//   current bottle. A full bottle (bot_full) runs the conveyor for MOVE_CYCLES
//   cycles. A complete batch (all_full) parks the feeder in DONE until conti.
//
//   Optional feature macro: PILL_FEEDER_JAM_EN
//     defined   : jam=1 in FEED freezes the interval timer, suppresses pill
//                 and raises jam_alarm; release reloads the timer.
//     undefined : jam is ignored and jam_alarm stays 0 (same port list).
//
// Parameters
//   PERIOD_W    width of the pill-interval setting
//   MOVE_CYCLES conveyor run length per bottle change (1..255)
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   EN_work    run enable; low pauses feeding
//   conti      restart after a DONE batch (level)
//   period     cycles between pills; 0 behaves as 1
//   bot_full   one-cycle pulse: current bottle full
//   all_full   level: batch complete
//   jam        jam sensor level
//   pill       one-cycle pulse per dropped pill
//   conveyor   high while a bottle change is in progress
//   cntL/cntH  BCD pill count of current bottle (ones/tens)
//   state      FSM state: IDLE=0 FEED=1 MOVE=2 DONE=3
//   jam_alarm  high while a jam holds feeding
//
// Handshake: there is no valid/ready channel here; every input is sampled on
//   each rising edge and every output is a register updated on that edge.
// -----------------------------------------------------------------------------
module pill_feeder #(
  parameter int PERIOD_W    = 8,
  parameter int MOVE_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN_work,
  input  logic                conti,
  input  logic [PERIOD_W-1:0] period,
  input  logic                bot_full,
  input  logic                all_full,
  input  logic                jam,
  output logic                pill,
  output logic                conveyor,
  output logic [3:0]          cntL,
  output logic [3:0]          cntH,
  output logic [1:0]          state,
  output logic                jam_alarm
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_MOVE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [PERIOD_W-1:0] timer_q, timer_n;
  logic [7:0]          mcnt_q, mcnt_n;
  logic                af_q, af_n;        // all_full seen during MOVE
  logic                pill_q, pill_n;
  logic                conveyor_q, conveyor_n;
  logic [3:0]          cnt_l_q, cnt_l_n;
  logic [3:0]          cnt_h_q, cnt_h_n;
  logic                jam_alarm_q, jam_alarm_n;

  logic [PERIOD_W-1:0] per_eff;
  assign per_eff = (period == '0) ? PERIOD_W'(1) : period;

`ifndef PILL_FEEDER_JAM_EN
  logic unused_jam;
  assign unused_jam = jam;
`endif

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      mcnt_q      <= '0;
      af_q        <= 1'b0;
      pill_q      <= 1'b0;
      conveyor_q  <= 1'b0;
      cnt_l_q     <= 4'd0;
      cnt_h_q     <= 4'd0;
      jam_alarm_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      timer_q     <= timer_n;
      mcnt_q      <= mcnt_n;
      af_q        <= af_n;
      pill_q      <= pill_n;
      conveyor_q  <= conveyor_n;
      cnt_l_q     <= cnt_l_n;
      cnt_h_q     <= cnt_h_n;
      jam_alarm_q <= jam_alarm_n;
    end
  end

  // Next-state logic. In FEED the exits are ordered all_full, bot_full,
  // EN_work. MOVE ignores everything until its cycle budget is spent.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (EN_work) state_n = ST_FEED;
      ST_FEED: begin
        if (all_full)      state_n = ST_DONE;
        else if (bot_full) state_n = ST_MOVE;
        else if (!EN_work) state_n = ST_IDLE;
      end
      ST_MOVE: begin
        if (mcnt_q == 8'd0) begin
          if (af_q || all_full) state_n = ST_DONE;
          else if (EN_work)     state_n = ST_FEED;
          else                  state_n = ST_IDLE;
        end
      end
      ST_DONE: if (conti && !all_full) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    timer_n     = timer_q;
    mcnt_n      = mcnt_q;
    af_n        = af_q;
    pill_n      = 1'b0;
    conveyor_n  = 1'b0;
    cnt_l_n     = cnt_l_q;
    cnt_h_n     = cnt_h_q;
    jam_alarm_n = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (state_n == ST_FEED) timer_n = per_eff;
      end
      ST_FEED: begin
        if (state_n == ST_MOVE) begin
          conveyor_n = 1'b1;
          mcnt_n     = 8'(MOVE_CYCLES - 1);
          af_n       = 1'b0;
        end else if (state_n == ST_FEED) begin
`ifdef PILL_FEEDER_JAM_EN
          if (jam) begin
            jam_alarm_n = 1'b1;           // timer frozen, no pill
          end else if (jam_alarm_q) begin
            timer_n = per_eff;            // jam released: restart interval
          end else
`endif
          begin
            // timer<=1 also catches a stray 0 so the interval never stalls
            if (timer_q <= PERIOD_W'(1)) begin
              pill_n  = 1'b1;
              timer_n = per_eff;
              if (cnt_l_q == 4'd9) begin
                cnt_l_n = 4'd0;
                cnt_h_n = (cnt_h_q == 4'd9) ? 4'd0 : cnt_h_q + 4'd1;
              end else begin
                cnt_l_n = cnt_l_q + 4'd1;
              end
            end else begin
              timer_n = timer_q - PERIOD_W'(1);
            end
          end
        end
      end
      ST_MOVE: begin
        if (state_n == ST_MOVE) begin
          conveyor_n = 1'b1;
          mcnt_n     = mcnt_q - 8'd1;
          af_n       = af_q | all_full;
        end else begin
          cnt_l_n = 4'd0;
          cnt_h_n = 4'd0;
          af_n    = 1'b0;
          if (state_n == ST_FEED) timer_n = per_eff;
        end
      end
      ST_DONE: begin
        if (state_n == ST_IDLE) begin
          cnt_l_n = 4'd0;
          cnt_h_n = 4'd0;
        end
      end
      default: ;
    endcase
  end

  assign pill      = pill_q;
  assign conveyor  = conveyor_q;
  assign cntL      = cnt_l_q;
  assign cntH      = cnt_h_q;
  assign state     = state_q;
  assign jam_alarm = jam_alarm_q;

endmodule

// File: tb/tb_pill_feeder.sv
module tb_pill_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_work = 1'b0;
  logic       conti = 1'b0;
  logic [7:0] period = 8'd0;
  logic       bot_full = 1'b0;
  logic       all_full = 1'b0;
  logic       jam = 1'b0;
  logic       pill, conveyor, jam_alarm;
  logic [3:0] cnt_l, cnt_h;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  pill_feeder #(.PERIOD_W(8), .MOVE_CYCLES(8)) dut (
    .CLK(clk), .RST(rst), .EN_work(en_work), .conti(conti), .period(period),
    .bot_full(bot_full), .all_full(all_full), .jam(jam), .pill(pill),
    .conveyor(conveyor), .cntL(cnt_l), .cntH(cnt_h), .state(state),
    .jam_alarm(jam_alarm)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // One rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_work = 1'b0; conti = 1'b0; bot_full = 1'b0;
    all_full = 1'b0; jam = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({state, pill, conveyor, cnt_h, cnt_l, jam_alarm} !== 13'd0) begin
      n_err++;
      $display("FAIL reset: state=%0d pill=%b conv=%b cnt=%h%h alarm=%b want all 0",
               state, pill, conveyor, cnt_h, cnt_l, jam_alarm);
    end
  endtask

  // period=3: pills at cycles 3,6,9 after FEED entry, count 01,02,03
  task automatic test_period3();
    do_reset();
    period = 8'd3; en_work = 1'b1;
    step();
    n_vec++;
    if (state !== 2'd1) begin n_err++; $display("FAIL p3_enter: state=%0d want 1", state); end
    for (int k = 1; k <= 9; k++) begin
      step();
      n_vec++;
      if (pill !== (k % 3 == 0)) begin
        n_err++; $display("FAIL p3_pill k=%0d: got %b want %b", k, pill, (k % 3 == 0));
      end
      if (k % 3 == 0) begin
        n_vec++;
        if ({cnt_h, cnt_l} !== 8'(k / 3)) begin
          n_err++; $display("FAIL p3_count k=%0d: got %h%h want 0%0d", k, cnt_h, cnt_l, k / 3);
        end
      end
    end
    // pause keeps count
    en_work = 1'b0;
    step();
    n_vec++;
    if (state !== 2'd0 || {cnt_h, cnt_l} !== 8'h03 || pill !== 1'b0) begin
      n_err++; $display("FAIL pause: state=%0d cnt=%h%h pill=%b want 0/03/0", state, cnt_h, cnt_l, pill);
    end
  endtask

  // period=0 behaves as 1: pill every cycle, BCD carry and 99->00 wrap
  task automatic test_period0();
    do_reset();
    period = 8'd0; en_work = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      n_vec++;
      if (pill !== 1'b1) begin n_err++; $display("FAIL p0_pill k=%0d: got %b want 1", k, pill); end
    end
    n_vec++;
    if ({cnt_h, cnt_l} !== 8'h12) begin n_err++; $display("FAIL p0_count12: got %h%h want 12", cnt_h, cnt_l); end
    for (int k = 0; k < 86; k++) step();
    n_vec++;
    if ({cnt_h, cnt_l} !== 8'h98) begin n_err++; $display("FAIL p0_count98: got %h%h want 98", cnt_h, cnt_l); end
    step();
    n_vec++;
    if ({cnt_h, cnt_l} !== 8'h99) begin n_err++; $display("FAIL p0_count99: got %h%h want 99", cnt_h, cnt_l); end
    step();
    n_vec++;
    if ({cnt_h, cnt_l} !== 8'h00) begin n_err++; $display("FAIL p0_wrap: got %h%h want 00", cnt_h, cnt_l); end
  endtask

  // bot_full on the expiring cycle: no pill, 8 conveyor cycles, count cleared
  task automatic test_bot_full();
    do_reset();
    period = 8'd3; en_work = 1'b1;
    step();                                  // enter FEED
    for (int k = 1; k <= 5; k++) step();     // pill at k=3 -> count 01, timer now 1
    bot_full = 1'b1;
    step();
    bot_full = 1'b0;
    n_vec++;
    if (pill !== 1'b0 || state !== 2'd2 || conveyor !== 1'b1) begin
      n_err++; $display("FAIL bf_enter: pill=%b state=%0d conv=%b want 0/2/1", pill, state, conveyor);
    end
    for (int k = 2; k <= 8; k++) begin
      bot_full = (k == 4);                   // ignored during MOVE
      step();
      n_vec++;
      if (conveyor !== 1'b1 || state !== 2'd2) begin
        n_err++; $display("FAIL bf_move k=%0d: conv=%b state=%0d want 1/2", k, conveyor, state);
      end
    end
    bot_full = 1'b0;
    step();
    n_vec++;
    if (conveyor !== 1'b0 || state !== 2'd1 || {cnt_h, cnt_l} !== 8'h00) begin
      n_err++; $display("FAIL bf_exit: conv=%b state=%0d cnt=%h%h want 0/1/00", conveyor, state, cnt_h, cnt_l);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++;
      if (pill !== (k == 3)) begin n_err++; $display("FAIL bf_resume k=%0d: got %b want %b", k, pill, (k == 3)); end
    end
  endtask

  // all_full raised during MOVE lands in DONE after the move
  task automatic test_move_all_full();
    do_reset();
    period = 8'd5; en_work = 1'b1;
    step();
    bot_full = 1'b1;
    step();
    bot_full = 1'b0;
    step();
    all_full = 1'b1;
    step();
    all_full = 1'b0;
    for (int k = 0; k < 5; k++) step();
    n_vec++;
    if (state !== 2'd2) begin n_err++; $display("FAIL mv_af_still_move: state=%0d want 2", state); end
    step();
    n_vec++;
    if (state !== 2'd3 || conveyor !== 1'b0) begin
      n_err++; $display("FAIL mv_af_done: state=%0d conv=%b want 3/0", state, conveyor);
    end
  endtask

  // all_full + bot_full in FEED -> DONE; conti with all_full=0 -> IDLE, 00
  task automatic test_all_full();
    do_reset();
    period = 8'd1; en_work = 1'b1;
    step();
    step(); step();                          // count 02
    all_full = 1'b1; bot_full = 1'b1;
    step();
    bot_full = 1'b0;
    n_vec++;
    if (state !== 2'd3 || conveyor !== 1'b0 || pill !== 1'b0) begin
      n_err++; $display("FAIL af_done: state=%0d conv=%b pill=%b want 3/0/0", state, conveyor, pill);
    end
    conti = 1'b1;
    step();
    n_vec++;
    if (state !== 2'd3) begin n_err++; $display("FAIL af_hold: state=%0d want 3", state); end
    all_full = 1'b0;
    step();
    conti = 1'b0;
    n_vec++;
    if (state !== 2'd0 || {cnt_h, cnt_l} !== 8'h00) begin
      n_err++; $display("FAIL af_restart: state=%0d cnt=%h%h want 0/00", state, cnt_h, cnt_l);
    end
  endtask

  // RST on the 4th MOVE cycle aborts the move
  task automatic test_reset_mid_move();
    do_reset();
    period = 8'd1; en_work = 1'b1;
    step();
    step(); step(); step();                  // count 03
    bot_full = 1'b1;
    step();                                  // MOVE cycle 1
    bot_full = 1'b0;
    step(); step(); step();                  // MOVE cycles 2..4
    n_vec++;
    if (state !== 2'd2 || {cnt_h, cnt_l} !== 8'h03) begin
      n_err++; $display("FAIL rm_pre: state=%0d cnt=%h%h want 2/03", state, cnt_h, cnt_l);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (state !== 2'd0 || conveyor !== 1'b0 || {cnt_h, cnt_l} !== 8'h00) begin
      n_err++; $display("FAIL rm_post: state=%0d conv=%b cnt=%h%h want 0/0/00", state, conveyor, cnt_h, cnt_l);
    end
  endtask

  // jam for 5 cycles with period=4
  task automatic test_jam();
    logic exp_pill, exp_alarm;
    do_reset();
    period = 8'd4; en_work = 1'b1;
    step();
    for (int k = 1; k <= 12; k++) begin
      jam = (k >= 3 && k <= 7);
      step();
`ifdef PILL_FEEDER_JAM_EN
      exp_pill  = (k == 12);                 // reload at k=8, pill 4 cycles later
      exp_alarm = (k >= 3 && k <= 7);
`else
      exp_pill  = (k % 4 == 0);
      exp_alarm = 1'b0;
`endif
      n_vec++;
      if (pill !== exp_pill || jam_alarm !== exp_alarm) begin
        n_err++; $display("FAIL jam k=%0d: pill=%b alarm=%b want %b/%b", k, pill, jam_alarm, exp_pill, exp_alarm);
      end
    end
    jam = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period3();
    test_period0();
    test_bot_full();
    test_move_all_full();
    test_all_full();
    test_reset_mid_move();
    test_jam();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
